// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types and defaults for the two-channel encoder capture block
package enc_pkg;

  localparam int CNT_W      = 64;
  localparam int SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_Z = 2'd1,
    ACTIVE = 2'd2
  } stm_t;

endpackage

// File: rtl/enc_cnt.sv
// rtl/enc_cnt.sv - one encoder channel: input sync, edge detect, arm/index FSM, counter, overflow
module enc_cnt
  import enc_pkg::*;
#(
  parameter int                 P_CNT_W   = CNT_W,
  parameter logic [P_CNT_W-1:0] P_CNT_MAX = {P_CNT_W{1'b1}},
  parameter int                 P_SYNC    = SYNC_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               a,
  input  logic               z,
  output logic               strobe,
  output logic               z_sync,
  output logic               overflow,
  output logic               ready,
  output logic [P_CNT_W-1:0] cnt_out
);

  logic [P_SYNC-1:0] a_sr;
  logic [P_SYNC-1:0] z_sr;
  logic [P_SYNC-1:0] arm_sr;
  logic              a_prev;
  logic              z_prev;
  logic              a_s;
  logic              z_s;
  logic              arm_s;
  logic              a_rise;
  logic              z_rise;

  stm_t              r_stm;
  stm_t              w_stm_nxt;
  logic              w_stm_active;

  logic [P_CNT_W-1:0] r_cnt;
  logic [P_CNT_W-1:0] w_cnt_inc;
  logic               w_wrap;
  logic               w_count;

  assign a_s    = a_sr[P_SYNC-1];
  assign z_s    = z_sr[P_SYNC-1];
  assign arm_s  = arm_sr[P_SYNC-1];
  assign a_rise = a_s & ~a_prev;
  assign z_rise = z_s & ~z_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      z_sr   <= '0;
      arm_sr <= '0;
      a_prev <= 1'b0;
      z_prev <= 1'b0;
    end else begin
      a_sr   <= {a_sr[P_SYNC-2:0], a};
      z_sr   <= {z_sr[P_SYNC-2:0], z};
      arm_sr <= {arm_sr[P_SYNC-2:0], arm};
      a_prev <= a_s;
      z_prev <= z_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_stm <= IDLE;
    else     r_stm <= w_stm_nxt;
  end

  // Disarm wins over everything, so a drop of arm mid-count lands in IDLE next cycle.
  always_comb begin
    w_stm_nxt = r_stm;
    if (!arm_s) begin
      w_stm_nxt = IDLE;
    end else begin
      case (r_stm)
        IDLE:    w_stm_nxt = WAIT_Z;
        WAIT_Z:  if (z_rise) w_stm_nxt = ACTIVE;
        ACTIVE:  w_stm_nxt = ACTIVE;
        default: w_stm_nxt = IDLE;
      endcase
    end
  end

  assign w_stm_active = (r_stm == ACTIVE);
  assign w_wrap       = (r_cnt == P_CNT_MAX);
  assign w_cnt_inc    = w_wrap ? '0 : r_cnt + P_CNT_W'(1);
  assign w_count      = w_stm_active & arm_s & a_rise;

  // r_cnt and cnt_out are both cleared while disarmed, which is what entering IDLE means.
  always_ff @(posedge clk) begin
    if (rst || !arm_s) begin
      r_cnt    <= '0;
      cnt_out  <= '0;
      overflow <= 1'b0;
      strobe   <= 1'b0;
    end else begin
      strobe <= w_count;
      if (w_count) begin
        r_cnt   <= w_cnt_inc;
        cnt_out <= w_cnt_inc;
        if (w_wrap) overflow <= 1'b1;
      end
    end
  end

  assign z_sync = z_s;
  assign ready  = w_stm_active;

endmodule

// File: rtl/enc_top.sv
// rtl/enc_top.sv - two-channel incremental encoder capture with forwarded select line
module enc_top
  import enc_pkg::*;
#(
  parameter int                 P_CNT_W   = CNT_W,
  parameter logic [P_CNT_W-1:0] P_CNT_MAX = {P_CNT_W{1'b1}},
  parameter int                 P_SYNC    = SYNC_DEPTH
) (
  input  logic               CLK,
  input  logic               I_RST,
  input  logic               I_ARM,
  input  logic               I_SEL,
  input  logic               I_A0,
  input  logic               I_A1,
  input  logic               I_Z0,
  input  logic               I_Z1,
  output logic               O_A0,
  output logic               O_A1,
  output logic               O_Z0,
  output logic               O_Z1,
  output logic               O_SEL,
  output logic [P_CNT_W-1:0] O_CNT_A0,
  output logic [P_CNT_W-1:0] O_CNT_A1,
  output logic               O_OVERFLOW_0,
  output logic               O_OVERFLOW_1,
  output logic               O_READY_0,
  output logic               O_READY_1
);

  logic [P_SYNC-1:0] sel_sr;

  always_ff @(posedge CLK) begin
    if (I_RST) sel_sr <= '0;
    else       sel_sr <= {sel_sr[P_SYNC-2:0], I_SEL};
  end

  assign O_SEL = sel_sr[P_SYNC-1];

  enc_cnt #(
    .P_CNT_W  (P_CNT_W),
    .P_CNT_MAX(P_CNT_MAX),
    .P_SYNC   (P_SYNC)
  ) ENC_CNT0 (
    .clk     (CLK),
    .rst     (I_RST),
    .arm     (I_ARM),
    .a       (I_A0),
    .z       (I_Z0),
    .strobe  (O_A0),
    .z_sync  (O_Z0),
    .overflow(O_OVERFLOW_0),
    .ready   (O_READY_0),
    .cnt_out (O_CNT_A0)
  );

  enc_cnt #(
    .P_CNT_W  (P_CNT_W),
    .P_CNT_MAX(P_CNT_MAX),
    .P_SYNC   (P_SYNC)
  ) ENC_CNT1 (
    .clk     (CLK),
    .rst     (I_RST),
    .arm     (I_ARM),
    .a       (I_A1),
    .z       (I_Z1),
    .strobe  (O_A1),
    .z_sync  (O_Z1),
    .overflow(O_OVERFLOW_1),
    .ready   (O_READY_1),
    .cnt_out (O_CNT_A1)
  );

endmodule

// File: tb/tb_enc_top.sv
// tb/tb_enc_top.sv - randomized and directed bench for enc_top, full-width and low-wrap instances
module tb_enc_top;

  localparam logic [63:0] MAX_W = 64'd5;

  logic clk;
  logic rst, arm, sel, a0, a1, z0, z1;

  logic        o_a   [2][2];
  logic        o_z   [2][2];
  logic        o_ovf [2][2];
  logic        o_rdy [2][2];
  logic [63:0] o_cnt [2][2];
  logic        o_sel [2];

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  enc_top dut_m (
    .CLK(clk), .I_RST(rst), .I_ARM(arm), .I_SEL(sel),
    .I_A0(a0), .I_A1(a1), .I_Z0(z0), .I_Z1(z1),
    .O_A0(o_a[0][0]), .O_A1(o_a[0][1]), .O_Z0(o_z[0][0]), .O_Z1(o_z[0][1]),
    .O_SEL(o_sel[0]), .O_CNT_A0(o_cnt[0][0]), .O_CNT_A1(o_cnt[0][1]),
    .O_OVERFLOW_0(o_ovf[0][0]), .O_OVERFLOW_1(o_ovf[0][1]),
    .O_READY_0(o_rdy[0][0]), .O_READY_1(o_rdy[0][1])
  );

  enc_top #(.P_CNT_MAX(MAX_W)) dut_w (
    .CLK(clk), .I_RST(rst), .I_ARM(arm), .I_SEL(sel),
    .I_A0(a0), .I_A1(a1), .I_Z0(z0), .I_Z1(z1),
    .O_A0(o_a[1][0]), .O_A1(o_a[1][1]), .O_Z0(o_z[1][0]), .O_Z1(o_z[1][1]),
    .O_SEL(o_sel[1]), .O_CNT_A0(o_cnt[1][0]), .O_CNT_A1(o_cnt[1][1]),
    .O_OVERFLOW_0(o_ovf[1][0]), .O_OVERFLOW_1(o_ovf[1][1]),
    .O_READY_0(o_rdy[1][0]), .O_READY_1(o_rdy[1][1])
  );

  // Reference model: inputs seen through a 2-cycle delay, 3-phase arm/index/count behaviour,
  // counts taken modulo (max+1).
  logic [63:0] maxv [2];
  int          phase [2][2];
  logic [63:0] m_cnt [2][2];
  logic        m_stb [2][2];
  logic        m_ovf [2][2];
  logic        ha [2][3];
  logic        hz [2][3];
  logic        harm [3];
  logic        hsel [3];

  initial begin
    maxv[0] = '1;
    maxv[1] = MAX_W;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 2; c++) begin
          phase[d][c] = 0; m_cnt[d][c] = '0; m_stb[d][c] = 0; m_ovf[d][c] = 0;
        end
      for (int i = 0; i < 3; i++) begin
        harm[i] = 0; hsel[i] = 0;
        for (int c = 0; c < 2; c++) begin ha[c][i] = 0; hz[c][i] = 0; end
      end
    end else begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 2; c++) begin
          m_stb[d][c] = 0;
          if (!harm[1]) begin
            phase[d][c] = 0; m_cnt[d][c] = '0; m_ovf[d][c] = 0;
          end else if (phase[d][c] == 0) begin
            phase[d][c] = 1;
          end else if (phase[d][c] == 1) begin
            if (hz[c][1] && !hz[c][2]) phase[d][c] = 2;
          end else if (ha[c][1] && !ha[c][2]) begin
            m_cnt[d][c] = 64'(({1'b0, m_cnt[d][c]} + 65'd1) % ({1'b0, maxv[d]} + 65'd1));
            if (m_cnt[d][c] == 0) m_ovf[d][c] = 1;
            m_stb[d][c] = 1;
          end
        end
      for (int i = 2; i > 0; i--) begin
        harm[i] = harm[i-1]; hsel[i] = hsel[i-1];
        for (int c = 0; c < 2; c++) begin ha[c][i] = ha[c][i-1]; hz[c][i] = hz[c][i-1]; end
      end
      harm[0] = arm; hsel[0] = sel;
      ha[0][0] = a0; ha[1][0] = a1; hz[0][0] = z0; hz[1][0] = z1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [63:0] sq_m0[$];
  logic [63:0] sq_w0[$];
  logic        oq_w0[$];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 2; c++) begin
          chk($sformatf("stb_d%0d_c%0d", d, c), 64'(o_a[d][c]), 64'(m_stb[d][c]));
          chk($sformatf("cnt_d%0d_c%0d", d, c), o_cnt[d][c], m_cnt[d][c]);
          chk($sformatf("ovf_d%0d_c%0d", d, c), 64'(o_ovf[d][c]), 64'(m_ovf[d][c]));
          chk($sformatf("rdy_d%0d_c%0d", d, c), 64'(o_rdy[d][c]), 64'(phase[d][c] == 2));
          chk($sformatf("z_d%0d_c%0d", d, c), 64'(o_z[d][c]), 64'(hz[c][1]));
        end
        chk($sformatf("sel_d%0d", d), 64'(o_sel[d]), 64'(hsel[1]));
      end
      if (o_a[0][0]) sq_m0.push_back(o_cnt[0][0]);
      if (o_a[1][0]) begin sq_w0.push_back(o_cnt[1][0]); oq_w0.push_back(o_ovf[1][0]); end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apulse0(input int hi, input int lo);
    a0 = 1; tick(hi); a0 = 0; tick(lo);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("%s_stb_d%0d_c%0d", tag, d, c), 64'(o_a[d][c]), 64'd0);
        chk($sformatf("%s_cnt_d%0d_c%0d", tag, d, c), o_cnt[d][c], 64'd0);
        chk($sformatf("%s_ovf_d%0d_c%0d", tag, d, c), 64'(o_ovf[d][c]), 64'd0);
        chk($sformatf("%s_rdy_d%0d_c%0d", tag, d, c), 64'(o_rdy[d][c]), 64'd0);
        chk($sformatf("%s_z_d%0d_c%0d", tag, d, c), 64'(o_z[d][c]), 64'd0);
      end
      chk($sformatf("%s_sel_d%0d", tag, d), 64'(o_sel[d]), 64'd0);
    end
  endtask

  int wexp[7] = '{1, 2, 3, 4, 5, 0, 1};
  int per[2];
  int off;

  initial begin
    rst = 1; arm = 0; sel = 0; a0 = 0; a1 = 0; z0 = 0; z1 = 0;
    tick(2);
    rst = 0;
    chk_en = 1;
    chk_all_zero("reset");

    // select forwarding latency
    sel = 1;
    tick(1);
    chk("sel_lat1", 64'(o_sel[0]), 64'd0);
    tick(1);
    chk("sel_lat2", 64'(o_sel[0]), 64'd1);
    sel = 0;

    // armed but no index pulse: nothing counts
    arm = 1;
    tick(6);
    for (int i = 0; i < 10; i++) begin
      a0 = 1; a1 = 1; tick(4); a0 = 0; a1 = 0; tick(4);
    end
    chk("noz_strobes", 64'(sq_m0.size()), 64'd0);
    chk("noz_ready", 64'(o_rdy[0][0]), 64'd0);
    chk("noz_cnt", o_cnt[0][0], 64'd0);

    // Z after every third A; first Z arrives after the third A, so 17 edges count
    for (int i = 0; i < 20; i++) begin
      a0 = 1; tick(250); a0 = 0;
      if (i % 3 == 2) begin z0 = 1; tick(1); z0 = 0; tick(249); end
      else tick(250);
    end
    chk("seq_len", 64'(sq_m0.size()), 64'd17);
    for (int k = 0; k < 17; k++) chk($sformatf("seq_%0d", k), sq_m0[k], 64'(k + 1));
    for (int k = 0; k < 7; k++) chk($sformatf("wrap_%0d", k), sq_w0[k], 64'(wexp[k]));
    chk("wrap_ovf_before", 64'(oq_w0[4]), 64'd0);
    chk("wrap_ovf_at0", 64'(oq_w0[5]), 64'd1);
    chk("wrap_ovf_sticky", 64'(oq_w0[16]), 64'd1);
    chk("seq_ready0", 64'(o_rdy[0][0]), 64'd1);
    chk("seq_ready1", 64'(o_rdy[0][1]), 64'd0);

    // disarm mid-count, then re-arm and restart from the next index
    arm = 0;
    tick(4);
    chk("disarm_ready", 64'(o_rdy[0][0]), 64'd0);
    chk("disarm_cnt", o_cnt[0][0], 64'd0);
    chk("disarm_ovf", 64'(o_ovf[1][0]), 64'd0);
    arm = 1;
    sq_m0.delete();
    tick(5);
    z0 = 1; tick(1); z0 = 0; tick(5);
    for (int i = 0; i < 3; i++) apulse0(3, 3);
    tick(4);
    chk("rearm_len", 64'(sq_m0.size()), 64'd3);
    for (int k = 0; k < 3; k++) chk($sformatf("rearm_%0d", k), sq_m0[k], 64'(k + 1));

    // A and Z rising together while waiting for the index: that A is not counted
    arm = 0; tick(4); arm = 1; tick(6);
    sq_m0.delete();
    a0 = 1; z0 = 1; tick(3); a0 = 0; z0 = 0; tick(3);
    apulse0(3, 3);
    tick(4);
    chk("same_len", 64'(sq_m0.size()), 64'd1);
    chk("same_first", sq_m0[0], 64'd1);
    chk("same_ready", 64'(o_rdy[0][0]), 64'd1);

    // random traffic, channels at different A rates, sel toggling, occasional disarm
    per[0] = 3; per[1] = 9; off = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, per[0]) == 0) a0 = ~a0;
      if ($urandom_range(0, per[1]) == 0) a1 = ~a1;
      z0 = ($urandom_range(0, 60) == 0);
      z1 = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 9) == 0) sel = ~sel;
      if (off > 0) begin
        arm = 0; off--;
      end else begin
        arm = 1;
        if ($urandom_range(0, 700) == 0) off = $urandom_range(1, 6);
      end
      tick(1);
    end

    // mid-run reset
    rst = 1; arm = 0; sel = 0; a0 = 0; a1 = 0; z0 = 0; z1 = 0;
    tick(2);
    rst = 0;
    chk_all_zero("reset2");
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
